// File: rtl/input_sequence_recorder_if.sv
// Channel-event recorder bus: raw channel levels and compare controls in,
// recorded string, status flags and compare result out.
interface input_sequence_recorder_if #(
  parameter int NUM_CH = 4,
  parameter int STR_W  = 64,
  parameter int CNT_W  = $clog2(STR_W + 1)
);
  logic [NUM_CH-1:0] ch_in;
  logic              clear;
  logic              check;
  logic [STR_W-1:0]  target;
  logic [CNT_W-1:0]  target_len;
  logic [STR_W-1:0]  seq_out;
  logic [CNT_W-1:0]  bit_count;
  logic              event_valid;
  logic [2:0]        event_ch;
  logic              collision;
  logic              overflow;
  logic              busy;
  logic              match_valid;
  logic              match;

  modport master (
    output ch_in, clear, check, target, target_len,
    input  seq_out, bit_count, event_valid, event_ch, collision, overflow,
           busy, match_valid, match
  );

  modport slave (
    input  ch_in, clear, check, target, target_len,
    output seq_out, bit_count, event_valid, event_ch, collision, overflow,
           busy, match_valid, match
  );
endinterface

// File: rtl/input_sequence_recorder.sv
// Records rising edges on asynchronous channels as a unary-coded bit string
// and compares the recording against a target on request.
//
// state | meaning
// REC   | appending channel codes, waiting for check
// CMP   | one cycle, evaluating the compare
// DONE  | result held, events and check ignored until clear
module input_sequence_recorder #(
  parameter int NUM_CH = 4,
  parameter int STR_W  = 64,
  parameter int CNT_W  = $clog2(STR_W + 1)
) (
  input logic                      clock,
  input logic                      reset,
  input_sequence_recorder_if.slave rec
);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {REC, CMP, DONE} state_t;

  state_t            state_q;
  logic [NUM_CH-1:0] sync1_q, sync2_q, hist_q;
  logic [STR_W-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              event_valid_q, collision_q, overflow_q;
  logic [2:0]        event_ch_q;
  logic              busy_q, match_valid_q, match_q;

  logic [NUM_CH-1:0] edge_w;
  logic              sel_found;
  logic [2:0]        sel_idx;
  logic              multi_w;
  logic [3:0]        code_len;
  logic [8:0]        ones_w;
  logic [STR_W-1:0]  code_w;
  logic [SUM_W-1:0]  sum_w;
  logic              ovf_w;

  assign edge_w  = sync2_q & ~hist_q;
  assign multi_w = (edge_w & (edge_w - NUM_CH'(1))) != '0;

  // Lowest channel index wins when several edges land in the same cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (edge_w[k]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(k);
      end
    end
  end

  assign code_len = {1'b0, sel_idx} + 4'd2;
  assign ones_w   = (9'd1 << (sel_idx + 3'd1)) - 9'd1;
  assign code_w   = STR_W'({ones_w, 1'b0});
  assign sum_w    = {1'b0, count_q} + SUM_W'(code_len);
  assign ovf_w    = sum_w > SUM_W'(STR_W);
  assign seq_d    = (seq_q << code_len) | code_w;
  assign count_d  = ovf_w ? CNT_W'(STR_W) : sum_w[CNT_W-1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= REC;
      sync1_q       <= '0;
      sync2_q       <= '0;
      hist_q        <= '0;
      seq_q         <= '0;
      count_q       <= '0;
      event_valid_q <= 1'b0;
      event_ch_q    <= 3'd0;
      collision_q   <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      match_valid_q <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      sync1_q       <= rec.ch_in;
      sync2_q       <= sync1_q;
      hist_q        <= sync2_q;
      event_valid_q <= 1'b0;
      match_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      if (rec.clear) begin
        state_q     <= REC;
        seq_q       <= '0;
        count_q     <= '0;
        collision_q <= 1'b0;
        overflow_q  <= 1'b0;
        match_q     <= 1'b0;
      end else begin
        case (state_q)
          REC: begin
            if (sel_found) begin
              seq_q         <= seq_d;
              count_q       <= count_d;
              event_valid_q <= 1'b1;
              event_ch_q    <= sel_idx;
              if (multi_w) collision_q <= 1'b1;
              if (ovf_w)   overflow_q  <= 1'b1;
            end
            if (rec.check) begin
              state_q <= CMP;
              busy_q  <= 1'b1;
            end
          end
          // Compare sees the string including any event appended with check.
          CMP: begin
            match_q       <= (seq_q == rec.target) && (count_q == rec.target_len)
                             && !overflow_q;
            match_valid_q <= 1'b1;
            state_q       <= DONE;
          end
          DONE:    state_q <= DONE;
          default: state_q <= REC;
        endcase
      end
    end
  end

  assign rec.seq_out     = seq_q;
  assign rec.bit_count   = count_q;
  assign rec.event_valid = event_valid_q;
  assign rec.event_ch    = event_ch_q;
  assign rec.collision   = collision_q;
  assign rec.overflow    = overflow_q;
  assign rec.busy        = busy_q;
  assign rec.match_valid = match_valid_q;
  assign rec.match       = match_q;
endmodule

// File: tb/tb_input_sequence_recorder.sv
// Bench for input_sequence_recorder: directed scenarios plus a randomized run
// against a string-level reference model.
module tb_input_sequence_recorder;
  localparam int NUM_CH = 4;
  localparam int STR_W  = 64;
  localparam int CNT_W  = 7;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  input_sequence_recorder_if #(.NUM_CH(NUM_CH), .STR_W(STR_W), .CNT_W(CNT_W)) bus ();

  input_sequence_recorder #(.NUM_CH(NUM_CH), .STR_W(STR_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (rst_n),
    .rec   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: sampled channel history, appended string, total bits.
  logic [NUM_CH-1:0] m_samp[$];
  logic [63:0]       m_str;
  int                m_total;
  bit                m_coll, m_rec_open, m_valid, m_busy, m_mv, m_match;
  int                m_since;
  int                m_ch;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_cnt();
    return (m_total > STR_W) ? STR_W : m_total;
  endfunction

  task automatic model_edge();
    logic [NUM_CH-1:0] rise;
    int k, len;
    logic [63:0] code;
    m_valid = 0;
    m_mv    = 0;
    m_busy  = 0;
    if (!rst_n) begin
      m_samp = '{'0, '0, '0};
      m_str = '0; m_total = 0; m_coll = 0; m_rec_open = 1;
      m_since = -1; m_ch = 0; m_match = 0;
      return;
    end
    rise = m_samp[1] & ~m_samp[2];
    m_samp.push_front(bus.ch_in);
    void'(m_samp.pop_back());
    if (bus.clear) begin
      m_str = '0; m_total = 0; m_coll = 0; m_match = 0;
      m_rec_open = 1; m_since = -1;
    end else if (m_rec_open) begin
      if (rise != '0) begin
        k = 0;
        while (!rise[k]) k++;
        len  = k + 2;
        code = ((64'd1 << (k + 1)) - 64'd1) << 1;
        m_str   = (m_str << len) | code;
        m_total += len;
        m_valid = 1;
        m_ch    = k;
        if ($countones(rise) > 1) m_coll = 1;
      end
      if (bus.check) begin
        m_rec_open = 0;
        m_since    = 0;
        m_busy     = 1;
      end
    end else if (m_since == 0) begin
      m_since = 1;
      m_mv    = 1;
      m_match = (m_str == bus.target) && (m_cnt() == int'(bus.target_len))
                && (m_total <= STR_W);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk_eq("seq_out",     bus.seq_out, m_str);
    chk_eq("bit_count",   64'(bus.bit_count), 64'(m_cnt()));
    chk_eq("event_valid", 64'(bus.event_valid), 64'(m_valid));
    chk_eq("event_ch",    64'(bus.event_ch), 64'(m_ch));
    chk_eq("collision",   64'(bus.collision), 64'(m_coll));
    chk_eq("overflow",    64'(bus.overflow), 64'(m_total > STR_W));
    chk_eq("busy",        64'(bus.busy), 64'(m_busy));
    chk_eq("match_valid", 64'(bus.match_valid), 64'(m_mv));
    chk_eq("match",       64'(bus.match), 64'(m_match));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    logic [63:0] ovf_str;
    int ev_count;

    bus.ch_in = '0; bus.clear = 0; bus.check = 0;
    bus.target = '0; bus.target_len = '0;
    m_samp = '{'0, '0, '0};

    // Reset state
    steps(2);
    rst_n = 1'b1;
    chk_eq("rst_seq", bus.seq_out, 64'd0);
    chk_eq("rst_cnt", 64'(bus.bit_count), 64'd0);

    // Single ch0 rise: update on 3rd sampling edge
    bus.ch_in = 4'b0001;
    steps(2);
    chk_eq("ch0_early_valid", 64'(bus.event_valid), 64'd0);
    step();
    chk_eq("ch0_valid", 64'(bus.event_valid), 64'd1);
    chk_eq("ch0_seq", bus.seq_out, 64'h2);
    chk_eq("ch0_cnt", 64'(bus.bit_count), 64'd2);
    chk_eq("ch0_ch", 64'(bus.event_ch), 64'd0);
    step();
    chk_eq("ch0_pulse_end", 64'(bus.event_valid), 64'd0);

    // ch2 then ch0
    bus.ch_in = '0; steps(3); do_clear();
    bus.ch_in = 4'b0100; steps(3);
    bus.ch_in = 4'b0101; steps(3);
    chk_eq("ch2ch0_seq", bus.seq_out, 64'h3A);
    chk_eq("ch2ch0_cnt", 64'(bus.bit_count), 64'd6);

    // Simultaneous ch1 and ch3
    bus.ch_in = '0; steps(3); do_clear();
    bus.ch_in = 4'b1010; steps(3);
    chk_eq("coll_seq", bus.seq_out, 64'h6);
    chk_eq("coll_cnt", 64'(bus.bit_count), 64'd3);
    chk_eq("coll_ch", 64'(bus.event_ch), 64'd1);
    chk_eq("coll_flag", 64'(bus.collision), 64'd1);

    // Overflow boundary with 22 ch1 events
    bus.ch_in = '0; steps(3); do_clear();
    ovf_str = '0;
    for (int i = 1; i <= 22; i++) begin
      bus.ch_in = 4'b0010; steps(3);
      ovf_str = (ovf_str << 3) | 64'h6;
      if (i == 21) begin
        chk_eq("ovf21_cnt", 64'(bus.bit_count), 64'd63);
        chk_eq("ovf21_flag", 64'(bus.overflow), 64'd0);
      end
      bus.ch_in = '0; steps(3);
    end
    chk_eq("ovf22_cnt", 64'(bus.bit_count), 64'd64);
    chk_eq("ovf22_flag", 64'(bus.overflow), 64'd1);
    chk_eq("ovf22_seq", bus.seq_out, ovf_str);

    // Record, compare, ignore later event, clear
    do_clear();
    bus.ch_in = 4'b0001; steps(3);
    bus.ch_in = 4'b0011; steps(3);
    chk_eq("cmp_seq", bus.seq_out, 64'h16);
    chk_eq("cmp_cnt", 64'(bus.bit_count), 64'd5);
    bus.target = 64'h16; bus.target_len = 7'd5; bus.check = 1'b1;
    step();
    bus.check = 1'b0;
    chk_eq("cmp_busy", 64'(bus.busy), 64'd1);
    step();
    chk_eq("cmp_mv", 64'(bus.match_valid), 64'd1);
    chk_eq("cmp_match", 64'(bus.match), 64'd1);
    chk_eq("cmp_busy_end", 64'(bus.busy), 64'd0);
    bus.ch_in = 4'b1011; steps(4);
    chk_eq("done_ignore_seq", bus.seq_out, 64'h16);
    do_clear();
    chk_eq("clear_seq", bus.seq_out, 64'd0);
    chk_eq("clear_match", 64'(bus.match), 64'd0);

    // Reset during CMP aborts without match_valid
    bus.check = 1'b1; step(); bus.check = 1'b0;
    rst_n = 1'b0; step();
    chk_eq("abort_mv", 64'(bus.match_valid), 64'd0);
    chk_eq("abort_busy", 64'(bus.busy), 64'd0);
    chk_eq("abort_ch", 64'(bus.event_ch), 64'd0);
    rst_n = 1'b1; step();
    chk_eq("abort_mv_after", 64'(bus.match_valid), 64'd0);

    // Channel held high through reset release gives one event
    bus.ch_in = 4'b0001; rst_n = 1'b0; steps(2);
    rst_n = 1'b1;
    ev_count = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      ev_count += int'(bus.event_valid);
    end
    chk_eq("held_rst_events", 64'(ev_count), 64'd1);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM_CH; b++)
        if ($urandom_range(0, 5) == 0) bus.ch_in[b] = ~bus.ch_in[b];
      bus.clear = ($urandom_range(0, 39) == 0);
      bus.check = ($urandom_range(0, 19) == 0);
      rst_n     = !($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) begin
        bus.target     = m_str;
        bus.target_len = 7'(m_cnt());
      end else begin
        bus.target     = {$urandom, $urandom};
        bus.target_len = 7'($urandom_range(0, 64));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/input_sequence_recorder.md
INPUT_SEQUENCE_RECORDER -- requirements
Module: input_sequence_recorder

Interface
REQ-001 Parameter: NUM_CH, default 4, number of input channels; legal range 1..7.
REQ-002 Parameter: STR_W, default 64, width of the recorded sequence string in bits; legal range 16..256.
REQ-003 Parameter: CNT_W, default $clog2(STR_W+1), width of the bit counter.
REQ-004 The port list SHALL be as follows, one port per line: name, direction, width, meaning.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- ch_in  input  NUM_CH  raw asynchronous channel levels; a rising edge is one event.
- clear  input  1  synchronous clear of the recorded string.
- check  input  1  single-cycle request to compare against the target.
- target  input  STR_W  expected encoded string.
- target_len  input  CNT_W  expected bit count.
- seq_out  output  STR_W  recorded encoded string.
- bit_count  output  CNT_W  number of valid bits in seq_out, saturating at STR_W.
- event_valid  output  1  one-cycle pulse when a code is appended.
- event_ch  output  3  channel index of the last appended code.
- collision  output  1  sticky flag for dropped simultaneous edges.
- overflow  output  1  sticky flag for string overflow.
- busy  output  1  high in the CMP state.
- match_valid  output  1  one-cycle pulse carrying the compare result.
- match  output  1  result of the last compare, held until clear or reset.

Function
REQ-005 Each ch_in bit SHALL pass through a 2-flop synchronizer followed by a history flop; an event is sync2=1 AND history=0.
REQ-006 For a ch_in bit that goes high and stays high for at least 2 cycles, seq_out, bit_count, event_valid and event_ch SHALL update on the 3rd rising edge at which that ch_in bit is sampled high.
REQ-007 Channel k (0-based) SHALL be encoded as k+1 ones followed by a single 0, giving a code length L = k+2 bits.
REQ-008 On an accepted event: seq_out <= (seq_out << L) | code; bits shifted past the MSB are discarded.
REQ-009 On an accepted event, bit_count <= min(bit_count + L, STR_W).
REQ-010 If bit_count + L > STR_W on an accepted event, overflow SHALL be set to 1 and remain set until clear or reset.
REQ-011 Multiple events in the same cycle: the lowest channel index is accepted, the others are dropped, and collision is set (sticky until clear or reset).
REQ-012 The FSM SHALL have three states: REC, CMP and DONE.
- REC: events are accepted; check=1 moves the FSM to CMP.
- CMP: lasts exactly one cycle; busy=1; events are ignored; the FSM then moves to DONE.
- DONE: match_valid=1 on the first cycle only; events are ignored; check is ignored.
REQ-013 The compare SHALL be registered on CMP entry and evaluate as match = (seq_out == target) AND (bit_count == target_len) AND NOT overflow.
REQ-014 match_valid SHALL pulse exactly 2 cycles after the cycle in which check was sampled high in REC.
REQ-015 clear=1 in any state SHALL take priority over events and check.
- Next edge: seq_out=0, bit_count=0, flags=0, match=0, state=REC.
- Synchronizer flops SHALL keep their values through clear.
REQ-016 An event and check arriving in the same cycle in REC: the event is appended first and check is then honoured, so the compare uses the updated string.
REQ-017 event_valid and match_valid SHALL be single-cycle pulses and SHALL be 0 in every other cycle.

Reset
REQ-018 reset=0 sampled at a rising edge SHALL force every output, every synchronizer flop and every history flop to 0, and the state to REC.
REQ-019 reset SHALL take priority over clear, check and events.
REQ-020 Reset asserted mid-operation, including in CMP or DONE, SHALL abort that operation with no match_valid pulse.
REQ-021 A channel held high through reset release SHALL produce exactly one event.

Verification (NUM_CH=4, STR_W=64)
REQ-022 Reset, then one ch0 rise -> seq_out=0x2, bit_count=2, event_ch=0, event_valid pulses on the 3rd edge.
REQ-023 ch2 rise then ch0 rise -> seq_out=0x3A, bit_count=6.
REQ-024 ch1 and ch3 rise in the same cycle -> seq_out=0x6, bit_count=3, event_ch=1, collision=1.
REQ-025 22 ch1 events -> after the 21st, bit_count=63 and overflow=0; after the 22nd, bit_count=64, overflow=1, seq_out=low 64 bits of the shifted string.
REQ-026 Record ch0 then ch1 -> seq_out=0x16, bit_count=5; set target=0x16, target_len=5, pulse check -> busy for 1 cycle, then match_valid=1 and match=1; a later ch3 rise is ignored; clear -> seq_out=0, state REC.
REQ-027 reset=0 during CMP -> no match_valid pulse, all outputs 0 at the next edge.
